// File: rtl/dm_store_rmw.sv
// Word-wide store unit for a data memory without byte enables.
// Full-word stores are written directly; halfword and byte stores read, merge and write back.
module dm_store_rmw #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [1:0]    op,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [31:0]   mem_wdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MRG,
    WR,
    ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] data_q;
  logic [31:0] wbuf;
  logic [31:0] merged;
  logic        reject;
  logic        unused_addr_hi;

  // High address bits fall outside the memory and are simply dropped.
  assign unused_addr_hi = ^addr[31:AW+2];

  always_comb begin
    reject = (op == 2'b11) ||
             ((op == 2'b00) && (addr[1:0] != 2'b00)) ||
             ((op == 2'b01) && addr[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (reject) begin
            state_nxt = ERR;
          end else if (op == 2'b00) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD:      state_nxt = MRG;
      MRG:     state_nxt = WR;
      WR:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane replacement over the word just read back from memory.
  always_comb begin
    merged = mem_rdata;
    if (op_q == 2'b10) begin
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = data_q;
    end else begin
      merged[15:0] = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      lane_q   <= 2'b00;
      data_q   <= 16'h0000;
      wbuf     <= 32'h0000_0000;
      mem_addr <= '0;
    end else if ((state == IDLE) && req) begin
      op_q     <= op;
      lane_q   <= addr[1:0];
      data_q   <= wdata[15:0];
      mem_addr <= addr[AW+1:2];
      if (op == 2'b00) begin
        wbuf <= wdata;
      end
    end else if (state == MRG) begin
      wbuf <= merged;
    end
  end

  assign ready     = (state == IDLE);
  assign mem_rd    = (state == RD);
  assign mem_we    = (state == WR);
  assign done      = (state == WR) || (state == ERR);
  assign err       = (state == ERR);
  assign mem_wdata = wbuf;

endmodule

// File: tb/tb_dm_store_rmw.sv
// Bench for dm_store_rmw: a registered memory model plus a byte-level reference of
// what each store must leave in memory, driven by directed and random requests.
module tb_dm_store_rmw;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;
  logic [31:0] exp_maddr;
  int          checks;
  int          errors;

  dm_store_rmw #(.AW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory; read data is garbage whenever no read was issued.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_rd ? mem[mem_addr] : $urandom;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request from an idle cycle and checks every cycle until ready returns.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] d, input bit hold);
    bit          rej;
    int          lat;
    int          idx;
    int          k;
    logic [7:0]  b [4];
    logic [31:0] new_w;

    check_output("ready_before_req", 32'(ready), 32'd1);
    rej = (o == 2'd3) || ((o == 2'd0) && (a % 4 != 0)) || ((o == 2'd1) && (a % 2 != 0));
    idx = int'((a >> 2) & 32'h3FF);
    k   = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = 8'(ref_mem[idx] >> (8 * i));
    if (o == 2'd0) begin
      for (int i = 0; i < 4; i++) b[i] = 8'(d >> (8 * i));
    end else if (o == 2'd1) begin
      b[k]     = d[7:0];
      b[k + 1] = d[15:8];
    end else if (o == 2'd2) begin
      b[k] = d[7:0];
    end
    new_w     = {b[3], b[2], b[1], b[0]};
    lat       = (rej || (o == 2'd0)) ? 1 : 3;
    exp_maddr = 32'(idx);

    req   = 1'b1;
    op    = o;
    addr  = a;
    wdata = d;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (hold) begin
        req   = 1'b1;
        op    = 2'($urandom);
        addr  = $urandom;
        wdata = $urandom;
      end else begin
        req = 1'b0;
      end
      check_output("ready_busy", 32'(ready), 32'd0);
      check_output("mem_rd", 32'(mem_rd), 32'((c == 1) && (lat == 3)));
      check_output("mem_we", 32'(mem_we), 32'((c == lat) && !rej));
      check_output("done", 32'(done), 32'(c == lat));
      check_output("err", 32'(err), 32'((c == lat) && rej));
      check_output("mem_addr", 32'(mem_addr), exp_maddr);
      if ((c == lat) && !rej) check_output("mem_wdata", mem_wdata, new_w);
    end
    if (!rej) ref_mem[idx] = new_w;
    @(negedge clk);
    check_output("ready_after_done", 32'(ready), 32'd1);
    check_output("done_after", 32'(done), 32'd0);
    check_output("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 1'b0;
    op     = 2'b00;
    addr   = 32'h0;
    wdata  = 32'h0;
    pl_en  = 1'b0;
    pl_idx = 10'd0;
    pl_val = 32'h0;
    exp_maddr = 32'h0;

    // Preload the words the bench touches while reset is held.
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      pl_en  = 1'b1;
      pl_idx = 10'(i);
      pl_val = (i < 2) ? 32'h1122_3344 : $urandom;
      ref_mem[i] = pl_val;
      @(negedge clk);
    end
    pl_en = 1'b0;

    check_output("rst_ready", 32'(ready), 32'd1);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed stores");
    apply_stimulus(2'd0, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0);
    check_output("sw_word2", mem[2], 32'hDEAD_BEEF);
    apply_stimulus(2'd2, 32'h0000_0006, 32'hFFFF_FFAB, 1'b0);
    check_output("sb_lane2", mem[1], 32'h11AB_3344);
    apply_stimulus(2'd1, 32'h0000_0002, 32'h0000_BEEF, 1'b0);
    check_output("sh_upper", mem[0], 32'hBEEF_3344);
    apply_stimulus(2'd1, 32'h0000_0000, 32'h0000_CAFE, 1'b0);
    check_output("sh_lower", mem[0], 32'hBEEF_CAFE);
    apply_stimulus(2'd0, 32'hFFFF_F00C, 32'h0BAD_F00D, 1'b0);
    check_output("sw_truncated", mem[3], 32'h0BAD_F00D);

    $display("[TB] rejects");
    apply_stimulus(2'd0, 32'h0000_0005, 32'h1234_5678, 1'b0);
    apply_stimulus(2'd1, 32'h0000_0003, 32'h1234_5678, 1'b0);
    apply_stimulus(2'd3, 32'h0000_0004, 32'h1234_5678, 1'b0);

    $display("[TB] back-to-back with req held high");
    for (int i = 0; i < 12; i++) begin
      apply_stimulus((i % 2 == 0) ? 2'd2 : 2'd0, ($urandom & 32'hFFFF_F03C) | 32'(i % 2 == 0 ? i % 4 : 0),
                     $urandom, 1'b1);
    end
    req = 1'b0;
    @(negedge clk);

    $display("[TB] reset during merge");
    req   = 1'b1;
    op    = 2'd2;
    addr  = 32'h0000_0005;
    wdata = 32'h0000_0077;
    @(negedge clk);
    req = 1'b0;
    check_output("abort_mem_rd", 32'(mem_rd), 32'd1);
    @(negedge clk);
    check_output("abort_in_mrg_we", 32'(mem_we), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("abort_ready", 32'(ready), 32'd1);
    check_output("abort_mem_we", 32'(mem_we), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_mem_addr", 32'(mem_addr), 32'd0);
    check_output("abort_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    check_output("abort_ready2", 32'(ready), 32'd1);
    check_output("abort_mem_word", mem[1], ref_mem[1]);

    $display("[TB] random stores");
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_F03F, $urandom,
                     1'($urandom_range(0, 1)));
    end
    req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_store_rmw.md
# dm_store_rmw

Store-side companion to the load extender in the data-memory path: it performs `sw`/`sh`/`sb` stores into a word-wide data memory that has no byte enables. Halfword and byte stores use a read-modify-write sequence. The block accepts one store request at a time from the MEM stage over a ready/req handshake. It sequences a synchronous read, merges the new lane(s) into the old word, and writes the whole word back. Misaligned or illegal stores are rejected with an error pulse and no memory access.

## Interface
- AW, 10, word-address width of the data memory; the memory holds 2^AW words.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  1  store request; sampled only while ready=1.
- op  in  2  store type: 00 sw, 01 sh, 10 sb, 11 illegal.
- addr  in  32  byte address of the store.
- wdata  in  32  store data; sh uses [15:0], sb uses [7:0].
- ready  out  1  block idle and able to accept a request.
- done  out  1  one-cycle pulse that ends each accepted request.
- err  out  1  one-cycle pulse, coincident with done, when the request was rejected.
- mem_addr  out  AW  word address, equal to the captured addr[AW+1:2].
- mem_rd  out  1  memory read strobe; read data is valid on mem_rdata in the following cycle.
- mem_rdata  in  32  memory read data.
- mem_we  out  1  memory write strobe; the full word is written.
- mem_wdata  out  32  memory write data.

## Operation
- States: IDLE, RD, MRG, WR, ERR.
- ready = (state==IDLE). All other outputs are decoded from registers only; there is no combinational path from any input to any output.
- IDLE, with req=1:
  - capture op, addr, and wdata.
  - rejection check, in this order:
    - op=11 → ERR.
    - sw with addr[1:0]≠00 → ERR.
    - sh with addr[0]=1 → ERR.
    - sb is never misaligned.
  - if accepted: sw → WR with wbuf=wdata; sh/sb → RD.
- IDLE, with req=0: remain in IDLE.
- RD: mem_rd=1 → MRG.
- MRG: merge mem_rdata into wbuf → WR. Merge rules:
  - sb, lane k=addr[1:0]: bits [8k+7:8k] take wdata[7:0]; other bits keep mem_rdata.
  - sh, addr[1]=0: [15:0] take wdata[15:0].
  - sh, addr[1]=1: [31:16] take wdata[15:0].
  - other halfword kept.
- WR: mem_we=1, mem_wdata=wbuf, done=1 → IDLE.
- ERR: done=1, err=1; mem_rd=mem_we=0 → IDLE.
- mem_addr holds the captured word address from the acceptance edge until the next acceptance. It is 0 after reset.
- Addresses with bits above AW+1 set are truncated, not rejected.
- While ready=0, req and all request inputs are ignored and need not be held stable.
- The block is the sole writer of the memory while busy; it provides no atomicity against other masters.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE
  - ready=1
  - done=err=mem_rd=mem_we=0
  - mem_addr=0, mem_wdata=0, wbuf=0
- Reset in any state aborts the request: no write and no done pulse. This holds even if reset is sampled at the edge ending RD or MRG.
- Latency is counted in cycles after the acceptance edge:
  - sw: WR in cycle 1 (done with the write).
  - sh/sb: RD in cycle 1, MRG in cycle 2, WR/done in cycle 3.
  - reject: ERR/done/err in cycle 1.
- ready is 0 from the cycle after acceptance through the done cycle. ready returns to 1 in the cycle after done.
- Maximum throughput: one sw every 2 cycles; one sh/sb every 4 cycles.
- mem_rdata is sampled only at the edge ending MRG; its value in any other cycle is irrelevant.

## Test plan
- Reset and sw:
  - Stimulus: after reset, check ready=1 and all strobes 0. Send req, sw, addr=0x0000_0008, wdata=0xDEAD_BEEF.
  - Required: in the next cycle, mem_we=1, mem_addr=2, mem_wdata=0xDEAD_BEEF, done=1; ready=1 in the cycle after.
- sb, lane 2:
  - Stimulus: memory word 1 = 0x1122_3344; send sb, addr=0x6, wdata=0xFFFF_FFAB.
  - Required: mem_rd in cycle 1; in cycle 3, mem_we=1 and mem_wdata=0x11AB_3344.
- sh, upper and lower halfword:
  - Stimulus: memory word 0 = 0x1122_3344. Send sh, addr=0x2, wdata=0x0000_BEEF; then sh, addr=0x0, wdata=0x0000_CAFE.
  - Required: first write 0xBEEF_3344; second write 0xBEEF_CAFE.
- Rejects:
  - Stimulus: send sw with addr=0x5, then sh with addr=0x3, then op=11.
  - Required: each gives done=err=1 one cycle after acceptance, with mem_rd=mem_we=0 throughout.
- Busy and back-to-back:
  - Stimulus: hold req=1 continuously with alternating sb/sw requests.
  - Required: a new request is accepted only on edges where ready=1; requests presented while busy are ignored; each accepted store yields exactly one done.
- Reset mid-operation:
  - Stimulus: drop rst_n while in MRG of an sb.
  - Required: no mem_we and no done are produced; ready=1 after the reset edge.
